// File: rtl/adder_16bit_pkg.sv
// Shared constants for the registered carry-lookahead adder.
package adder_16bit_pkg;
  localparam int WIDTH_DEFAULT = 16;
  localparam int GROUP_SIZE    = 4;
endpackage

// File: rtl/adder_16bit_if.sv
// Operand/result bundle between the adder and whatever drives it.
interface adder_16bit_if #(
  parameter int WIDTH = adder_16bit_pkg::WIDTH_DEFAULT
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (output a, output b, output cin, input sum, input cout, input overflow);
  modport slave  (input a, input b, input cin, output sum, output cout, output overflow);
endinterface

// File: rtl/adder_16bit_cla_4bit.sv
// 4-bit carry-lookahead slice: flattened internal carries plus group P/G.
module cla_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       pg_o,
  output logic       gg_o
);
  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  // Each carry is a two-level sum of products of cin, so there is no ripple.
  assign c[0] = cin_i;
  assign c[1] = g[0] | (p[0] & cin_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);

  assign sum_o = p ^ c;
  assign pg_o  = &p;
  assign gg_o  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
endmodule

// File: rtl/adder_16bit.sv
// Registered adder: 4-bit CLA slices, second-level lookahead across groups,
// signed overflow from operand/result MSBs, one output register stage.
module adder_16bit
  import adder_16bit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  adder_16bit_if.slave  bus
);
  localparam int NGROUPS = WIDTH / GROUP_SIZE;

  logic [WIDTH-1:0]   sum_d;
  logic               cout_d;
  logic               overflow_d;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               overflow_q;
  logic [NGROUPS-1:0] gp;
  logic [NGROUPS-1:0] gg;
  logic [NGROUPS:0]   gc;

  generate
    for (genvar gi = 0; gi < NGROUPS; gi++) begin : g_cla
      cla_4bit u_cla (
        .a_i   (bus.a[gi*GROUP_SIZE +: GROUP_SIZE]),
        .b_i   (bus.b[gi*GROUP_SIZE +: GROUP_SIZE]),
        .cin_i (gc[gi]),
        .sum_o (sum_d[gi*GROUP_SIZE +: GROUP_SIZE]),
        .pg_o  (gp[gi]),
        .gg_o  (gg[gi])
      );
    end
  endgenerate

  // Group carry j = OR_k (G[k] & P[k+1..j-1]) | (P[0..j-1] & cin), fully expanded.
  always_comb begin
    logic c_acc;
    logic term;
    gc    = '0;
    gc[0] = bus.cin;
    for (int j = 1; j <= NGROUPS; j++) begin
      c_acc = bus.cin;
      for (int k = 0; k < j; k++) c_acc = c_acc & gp[k];
      for (int k = 0; k < j; k++) begin
        term = gg[k];
        for (int m = k + 1; m < j; m++) term = term & gp[m];
        c_acc = c_acc | term;
      end
      gc[j] = c_acc;
    end
  end

  assign cout_d     = gc[NGROUPS];
  assign overflow_d = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_d[WIDTH-1] != bus.a[WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q      <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_adder_16bit.sv
// Scoreboard bench for adder_16bit: reset, directed corners, random back-to-back.
module tb_adder_16bit;
  import adder_16bit_pkg::*;

  localparam int W = WIDTH_DEFAULT;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  adder_16bit_if #(.WIDTH(W)) bus ();

  adder_16bit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: zero-extended add, signed overflow from operand/result MSBs.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] s;
    exp_t       e;
    s     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    e.sum = s[W-1:0];
    e.cout = s[W];
    e.ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    return e;
  endfunction

  // Drive one vector, queue its expectation, advance to just after the edge.
  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input exp_t e);
    bus.a   = a;
    bus.b   = b;
    bus.cin = c;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    bus.a = 16'h1234; bus.b = 16'h1111; bus.cin = 1'b0;
    #2;
    total++;
    if ({bus.sum, bus.cout, bus.overflow} !== 18'h0) begin
      bad++; $display("FAIL reset_initial got sum=%h cout=%b ovf=%b want 0000/0/0", bus.sum, bus.cout, bus.overflow);
    end
    @(posedge clk); #1;
    total++;
    if ({bus.sum, bus.cout, bus.overflow} !== 18'h0) begin
      bad++; $display("FAIL reset_hold got sum=%h cout=%b ovf=%b want 0000/0/0", bus.sum, bus.cout, bus.overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({bus.sum, bus.cout, bus.overflow} !== 18'h0) begin
      bad++; $display("FAIL reset_release_pre_edge got sum=%h want 0000", bus.sum);
    end
    sb.push_back('{sum: 16'h2345, cout: 1'b0, ovf: 1'b0});
    @(posedge clk); #1;
    e = sb.pop_front();
    total++;
    $display("txn reset_first a=1234 b=1111 cin=0 -> sum=%h cout=%b ovf=%b", bus.sum, bus.cout, bus.overflow);
    if ({bus.sum, bus.cout, bus.overflow} !== e) begin
      bad++; $display("FAIL reset_first got %h/%b/%b want %h/%b/%b", bus.sum, bus.cout, bus.overflow, e.sum, e.cout, e.ovf);
    end
    // Mid-operation reset: a pending non-zero result must vanish immediately.
    apply(16'hFFFF, 16'h0001, 1'b0, '{sum: 16'h0000, cout: 1'b1, ovf: 1'b0});
    void'(sb.pop_front());
    bus.a = 16'h0F0F; bus.b = 16'h0101; bus.cin = 1'b1;
    rst = 1'b1;
    #1;
    total++;
    if ({bus.sum, bus.cout, bus.overflow} !== 18'h0) begin
      bad++; $display("FAIL reset_async_assert got sum=%h cout=%b ovf=%b want 0000/0/0", bus.sum, bus.cout, bus.overflow);
    end
    @(posedge clk); #1;
    total++;
    if ({bus.sum, bus.cout, bus.overflow} !== 18'h0) begin
      bad++; $display("FAIL reset_discard got sum=%h want 0000", bus.sum);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic c, input exp_t want);
    exp_t e;
    apply(a, b, c, want);
    total++;
    if (sb.size() == 0) begin
      bad++; $display("FAIL %s scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      $display("txn %s a=%h b=%h cin=%b -> sum=%h cout=%b ovf=%b", name, a, b, c, bus.sum, bus.cout, bus.overflow);
      if ({bus.sum, bus.cout, bus.overflow} !== e) begin
        bad++; $display("FAIL %s got %h/%b/%b want %h/%b/%b", name, bus.sum, bus.cout, bus.overflow, e.sum, e.cout, e.ovf);
      end
    end
  endtask

  task automatic test_basic();
    test_directed("basic_1p2", 16'h0001, 16'h0002, 1'b0, '{sum: 16'h0003, cout: 1'b0, ovf: 1'b0});
    test_directed("basic_1p1c", 16'h0001, 16'h0001, 1'b1, '{sum: 16'h0003, cout: 1'b0, ovf: 1'b0});
  endtask

  task automatic test_corners();
    test_directed("wrap", 16'hFFFF, 16'h0001, 1'b0, '{sum: 16'h0000, cout: 1'b1, ovf: 1'b0});
    test_directed("carry_chain", 16'hFFFF, 16'h0000, 1'b1, '{sum: 16'h0000, cout: 1'b1, ovf: 1'b0});
    test_directed("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, '{sum: 16'h8000, cout: 1'b0, ovf: 1'b1});
    test_directed("neg_ovf", 16'h8000, 16'h8000, 1'b0, '{sum: 16'h0000, cout: 1'b1, ovf: 1'b1});
    test_directed("near_ovf", 16'h7FFE, 16'h0001, 1'b0, '{sum: 16'h7FFF, cout: 1'b0, ovf: 1'b0});
  endtask

  task automatic test_boundaries();
    test_directed("zero", 16'h0000, 16'h0000, 1'b0, '{sum: 16'h0000, cout: 1'b0, ovf: 1'b0});
    test_directed("all_ones", 16'hFFFF, 16'h0000, 1'b0, '{sum: 16'hFFFF, cout: 1'b0, ovf: 1'b0});
    test_directed("cin_only", 16'h0000, 16'h0000, 1'b1, '{sum: 16'h0001, cout: 1'b0, ovf: 1'b0});
  endtask

  // New inputs every cycle; each result is popped and checked exactly one edge later.
  task automatic test_back_to_back();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    exp_t         e;
    for (int i = 0; i < 120; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      c = 1'($urandom);
      apply(a, b, c, model(a, b, c));
      total++;
      if (sb.size() == 0) begin
        bad++; $display("FAIL rand%0d scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        $display("txn rand%0d a=%h b=%h cin=%b -> sum=%h cout=%b ovf=%b", i, a, b, c, bus.sum, bus.cout, bus.overflow);
        if ({bus.sum, bus.cout, bus.overflow} !== e) begin
          bad++; $display("FAIL rand%0d got %h/%b/%b want %h/%b/%b", i, bus.sum, bus.cout, bus.overflow, e.sum, e.cout, e.ovf);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_boundaries();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adder_16bit.md
ADDER_16BIT -- requirements
Module: adder_16bit

Interface
REQ-001 Parameter: WIDTH, default 16, operand/sum width in bits; SHALL be a multiple of 4; all requirements below are stated for WIDTH=16.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: a  input  16  operand A, unsigned or two's-complement.
REQ-005 Port: b  input  16  operand B, unsigned or two's-complement.
REQ-006 Port: cin  input  1  carry-in added at bit 0.
REQ-007 Port: sum  output  16  registered result bits [15:0] of a+b+cin.
REQ-008 Port: cout  output  1  registered carry-out of bit 15 (unsigned overflow).
REQ-009 Port: overflow  output  1  registered two's-complement signed overflow flag.
REQ-010 The design SHALL have one clock, and reset SHALL be asynchronous and active-high.

Function
REQ-011 {cout,sum} SHALL equal the 17-bit value a+b+cin, computed with zero-extension.
REQ-012 overflow SHALL be 1 exactly when a[15]==b[15] and the result sum[15]!=a[15], cin included; otherwise 0.
REQ-013 Outputs SHALL be registered: inputs present before rising edge N appear on sum/cout/overflow after edge N (latency 1 cycle, throughput 1 result/cycle).
REQ-014 Outputs SHALL hold their value between edges; no combinational path from a/b/cin to any output.
REQ-015 Wrap-around: 0xFFFF+0x0001+0 -> sum 0x0000, cout 1, overflow 0.
REQ-016 Full carry chain: 0xFFFF+0x0000+1 -> sum 0x0000, cout 1, overflow 0.
REQ-017 Positive overflow: 0x7FFF+0x0001+0 -> sum 0x8000, cout 0, overflow 1.
REQ-018 Negative overflow: 0x8000+0x8000+0 -> sum 0x0000, cout 1, overflow 1.
REQ-019 cout and overflow SHALL be independent; any of the four combinations SHALL be producible.
REQ-020 X/Z on inputs is out of scope; no input validity checking.

Reset
REQ-021 While rst=1, sum SHALL be 0x0000, cout 0, overflow 0, asynchronously and immediately on assertion.
REQ-022 Reset asserted mid-operation SHALL discard the pending result; first valid output is the result of inputs sampled at the first rising edge after rst deasserts.
REQ-023 Reset deassertion SHALL be usable asynchronously to clk (no outputs other than reset values until that first edge).

Structure
REQ-024 Datapath SHALL be carry-lookahead: WIDTH/4 instances of sub-module cla_4bit (inputs a,b,cin; outputs sum, group propagate P, group generate G), plus a second-level lookahead computing the group carries from P/G.
REQ-025 cla_4bit SHALL compute bit-level p=a^b, g=a&b, internal carries by lookahead equations (no ripple), sum=p^carry.
REQ-026 Overflow SHALL be derived from operand and result MSBs (equivalently carry-into-MSB XOR cout), inside adder_16bit.
REQ-027 A shared package SHALL hold WIDTH default and the group size constant (4); no typedefs otherwise required.
REQ-028 Output register stage SHALL be a single always block with async reset in adder_16bit.

Verification
REQ-029 Reset: assert rst with a=0x1234, b=0x1111 -> sum 0x0000, cout 0, overflow 0 immediately; deassert, one edge -> sum 0x2345.
REQ-030 Basic: a=0x0001, b=0x0002, cin=0 -> after 1 edge sum 0x0003, cout 0, overflow 0; a=0x0001, b=0x0001, cin=1 -> sum 0x0003.
REQ-031 Carry/overflow corners: the four cases of REQ-015..REQ-018 plus 0x7FFE+0x0001 -> sum 0x7FFF, overflow 0.
REQ-032 Boundaries: 0x0000+0x0000+0 -> 0x0000/0/0; 0xFFFF+0x0000+0 -> 0xFFFF/0/0; 0x0000+0x0000+1 -> 0x0001/0/0.
REQ-033 Random: 100+ back-to-back random a, b, cin vectors, one per cycle -> each output equals reference {cout,sum}=a+b+cin and signed-overflow rule, checked one cycle later.
REQ-034 Pipelining: change inputs every cycle -> each result appears exactly one edge after its inputs, with no bubble or duplication.
